// File: rtl/regfile_writeback_arbiter.sv
// -----------------------------------------------------------------------------
// regfile_writeback_arbiter
//
// Shares the register file's single write port among NUM_REQ writeback
// sources (ALU, load unit, multiplier, ...) using round-robin arbitration
// with a per-source valid/ready handshake. It also keeps a pending-write
// scoreboard so the issue stage can detect RAW hazards on its two read
// addresses.
//
// Write-port outputs are registered on posedge clk. The register file writes
// on negedge, which gives it half a cycle of setup.
//
// Ports
//   clk              clock, all state updates on posedge
//   reset            synchronous, active-high reset
//   req_valid  [N]   per-source writeback request
//   req_ready  [N]   per-source grant (one-hot or zero); valid&ready = transfer
//   req_addr   [N*A] packed destination addresses, source i at [i*A +: A]
//   req_data   [N*D] packed write data, packed the same way
//   rf_address_3     registered write address to the register file
//   rf_write_data    registered write data
//   rf_write_enable  registered write strobe (never set for x0)
//   grant_id   [3]   registered index of the last accepted source
//   issue_valid      an instruction with a destination is issuing
//   issue_addr       destination register of that instruction
//   query_addr_1/2   read addresses of the issuing instruction
//   hazard_1/2       combinational: query address has a pending write
// -----------------------------------------------------------------------------
module regfile_writeback_arbiter #(
  parameter int NUM_REQ = 3,
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 5
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [ADDR_W-1:0]         rf_address_3,
  output logic [DATA_W-1:0]         rf_write_data,
  output logic                      rf_write_enable,
  output logic [2:0]                grant_id,
  input  logic                      issue_valid,
  input  logic [ADDR_W-1:0]         issue_addr,
  input  logic [ADDR_W-1:0]         query_addr_1,
  input  logic [ADDR_W-1:0]         query_addr_2,
  output logic                      hazard_1,
  output logic                      hazard_2
);

  localparam int NUM_REGS = 1 << ADDR_W;

  // Round-robin pointer: the source with the highest priority next cycle.
  logic [2:0]          ptr_q, ptr_d;
  logic [NUM_REGS-1:0] busy_q, busy_d;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   data_q;
  logic                we_q;
  logic [2:0]          gid_q;

  logic [NUM_REQ-1:0]  grant_oh;
  logic [2:0]          grant_idx;
  logic                xfer;
  logic [ADDR_W-1:0]   sel_addr;
  logic [DATA_W-1:0]   sel_data;

  // Arbitration: visit sources in order of their distance from the pointer
  // (modulo NUM_REQ) and grant the first valid one. The grant is built only
  // from req_valid and the pointer, never from another source's ready.
  always_comb begin
    // NOTE: every variable gets a default before any conditional assignment,
    // otherwise a path that skips the assignment infers a latch.
    grant_oh  = '0;
    grant_idx = '0;
    xfer      = 1'b0;
    for (int d = 0; d < NUM_REQ; d++) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!xfer && !reset && req_valid[i] &&
            ((i - int'(ptr_q) + NUM_REQ) % NUM_REQ) == d) begin
          xfer        = 1'b1;
          grant_oh[i] = 1'b1;
          grant_idx   = 3'(i);
        end
      end
    end
  end

  assign req_ready = grant_oh;

  // Steer the granted source's address and data.
  always_comb begin
    sel_addr = '0;
    sel_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_oh[i]) begin
        sel_addr = req_addr[i*ADDR_W +: ADDR_W];
        sel_data = req_data[i*DATA_W +: DATA_W];
      end
    end
  end

  // Pointer moves just past the accepted source, and holds otherwise.
  always_comb begin
    ptr_d = ptr_q;
    if (xfer) begin
      ptr_d = (int'(grant_idx) + 1 == NUM_REQ) ? 3'd0 : grant_idx + 3'd1;
    end
  end

  // Scoreboard next state. The clear is applied before the set, so when a
  // writeback and a new issue target the same register, the newer producer
  // keeps the bit busy. Register x0 is never busy.
  always_comb begin
    busy_d = busy_q;
    if (xfer && sel_addr != '0) begin
      busy_d[sel_addr] = 1'b0;
    end
    if (issue_valid && issue_addr != '0) begin
      busy_d[issue_addr] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples values from before the edge, whatever the statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_q  <= '0;
      // NOTE: the scoreboard is a bank of flops, not a RAM, so it is reset
      // like any other state. Stale busy bits would stall issue forever.
      busy_q <= '0;
      addr_q <= '0;
      data_q <= '0;
      we_q   <= 1'b0;
      gid_q  <= '0;
    end else begin
      ptr_q  <= ptr_d;
      busy_q <= busy_d;
      // A write to x0 completes the handshake but never strobes the file.
      we_q   <= xfer && (sel_addr != '0);
      if (xfer) begin
        addr_q <= sel_addr;
        data_q <= sel_data;
        gid_q  <= grant_idx;
      end
    end
  end

  assign rf_address_3    = addr_q;
  assign rf_write_data   = data_q;
  assign rf_write_enable = we_q;
  assign grant_id        = gid_q;

  // No bypass: a writeback accepted this cycle clears its hazard at the
  // next posedge.
  assign hazard_1 = busy_q[query_addr_1];
  assign hazard_2 = busy_q[query_addr_2];

endmodule

// File: tb/tb_regfile_writeback_arbiter.sv
// -----------------------------------------------------------------------------
// tb_regfile_writeback_arbiter
//
// Directed scenarios followed by a randomized phase. Each cycle is checked
// against a behavioural reference model of the arbiter, scoreboard and a
// negedge-written register file.
// -----------------------------------------------------------------------------
module tb_regfile_writeback_arbiter;

  localparam int NUM_REQ = 3;
  localparam int DATA_W  = 32;
  localparam int ADDR_W  = 5;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                      reset;
  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ-1:0]        req_ready;
  logic [NUM_REQ*ADDR_W-1:0] req_addr;
  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic [ADDR_W-1:0]         rf_address_3;
  logic [DATA_W-1:0]         rf_write_data;
  logic                      rf_write_enable;
  logic [2:0]                grant_id;
  logic                      issue_valid;
  logic [ADDR_W-1:0]         issue_addr;
  logic [ADDR_W-1:0]         query_addr_1;
  logic [ADDR_W-1:0]         query_addr_2;
  logic                      hazard_1;
  logic                      hazard_2;

  logic [ADDR_W-1:0] src_addr [NUM_REQ];
  logic [DATA_W-1:0] src_data [NUM_REQ];

  always_comb begin
    req_addr = '0;
    req_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      req_addr[i*ADDR_W +: ADDR_W] = src_addr[i];
      req_data[i*DATA_W +: DATA_W] = src_data[i];
    end
  end

  regfile_writeback_arbiter #(
    .NUM_REQ(NUM_REQ), .DATA_W(DATA_W), .ADDR_W(ADDR_W)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_addr       (req_addr),
    .req_data       (req_data),
    .rf_address_3   (rf_address_3),
    .rf_write_data  (rf_write_data),
    .rf_write_enable(rf_write_enable),
    .grant_id       (grant_id),
    .issue_valid    (issue_valid),
    .issue_addr     (issue_addr),
    .query_addr_1   (query_addr_1),
    .query_addr_2   (query_addr_2),
    .hazard_1       (hazard_1),
    .hazard_2       (hazard_2)
  );

  // Register file fed by the DUT: negedge write, x0 hardwired to zero.
  logic [DATA_W-1:0] rf_mem [32] = '{default: '0};
  always @(negedge clk) begin
    if (rf_write_enable && rf_address_3 != '0) rf_mem[rf_address_3] <= rf_write_data;
  end

  // Reference model state.
  int                m_ptr;
  logic [31:0]       m_busy;
  logic              m_we;
  logic [ADDR_W-1:0] m_addr;
  logic [DATA_W-1:0] m_data;
  int                m_gid;
  logic [DATA_W-1:0] m_regs [32];

  int total = 0;
  int bad   = 0;
  int g;
  int last_g;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // First valid source found walking from the pointer, wrapping round.
  function automatic int model_grant();
    if (reset) return -1;
    for (int off = 0; off < NUM_REQ; off++) begin
      int s;
      s = (m_ptr + off) % NUM_REQ;
      if (req_valid[s]) return s;
    end
    return -1;
  endfunction

  // One clock cycle. Inputs are already applied (posedge+1). Combinational
  // outputs are checked mid-cycle, the model advances at the posedge, and
  // the registered outputs are checked at posedge+1.
  task automatic cycle(output int gr);
    logic [NUM_REQ-1:0] exp_rdy;
    #3;
    gr = model_grant();
    exp_rdy = (gr >= 0) ? NUM_REQ'(1 << gr) : '0;
    check("req_ready", 64'(req_ready), 64'(exp_rdy));
    check("hazard_1", 64'(hazard_1), 64'(m_busy[query_addr_1]));
    check("hazard_2", 64'(hazard_2), 64'(m_busy[query_addr_2]));
    @(posedge clk);
    if (reset) begin
      m_ptr  = 0;
      m_busy = '0;
      m_we   = 1'b0;
      m_addr = '0;
      m_data = '0;
      m_gid  = 0;
    end else begin
      if (gr >= 0) begin
        m_addr = src_addr[gr];
        m_data = src_data[gr];
        m_gid  = gr;
        m_we   = (src_addr[gr] != '0);
        m_ptr  = (gr + 1) % NUM_REQ;
        if (m_we) begin
          m_busy[m_addr] = 1'b0;
          m_regs[m_addr] = m_data;
        end
      end else begin
        m_we = 1'b0;
      end
      if (issue_valid && issue_addr != '0) m_busy[issue_addr] = 1'b1;
    end
    #1;
    check("rf_write_enable", 64'(rf_write_enable), 64'(m_we));
    check("rf_address_3", 64'(rf_address_3), 64'(m_addr));
    check("rf_write_data", 64'(rf_write_data), 64'(m_data));
    check("grant_id", 64'(grant_id), 64'(3'(m_gid)));
  endtask

  task automatic idle();
    req_valid   = '0;
    issue_valid = 1'b0;
    issue_addr  = '0;
  endtask

  initial begin
    m_ptr  = 0;
    m_busy = '0;
    m_we   = 1'b0;
    m_addr = '0;
    m_data = '0;
    m_gid  = 0;
    for (int r = 0; r < 32; r++) m_regs[r] = '0;
    last_g = -1;

    // Reset held with every source requesting.
    reset        = 1'b1;
    req_valid    = '1;
    src_addr[0]  = 5'd5;  src_data[0] = 32'hA0;
    src_addr[1]  = 5'd6;  src_data[1] = 32'hB1;
    src_addr[2]  = 5'd7;  src_data[2] = 32'hC2;
    issue_valid  = 1'b0;
    issue_addr   = '0;
    query_addr_1 = 5'd5;
    query_addr_2 = 5'd6;
    @(posedge clk);
    #1;
    cycle(g);
    cycle(g);
    check("reset_we", 64'(rf_write_enable), 64'd0);
    check("reset_hazard_1", 64'(hazard_1), 64'd0);

    // Round robin: grants 0,1,2,0 on consecutive cycles.
    reset = 1'b0;
    cycle(g); check("rr_grant0", 64'(grant_id), 64'd0);
    cycle(g); check("rr_grant1", 64'(grant_id), 64'd1);
    cycle(g); check("rr_grant2", 64'(grant_id), 64'd2);
    cycle(g); check("rr_grant3", 64'(grant_id), 64'd0);
    check("rf_x5", 64'(rf_mem[5]), 64'hA0);
    check("rf_x6", 64'(rf_mem[6]), 64'hB1);
    check("rf_x7", 64'(rf_mem[7]), 64'hC2);

    // x0 write from source 1 alone: handshake completes, no strobe.
    req_valid   = 3'b010;
    src_addr[1] = 5'd0;
    src_data[1] = 32'hDEADBEEF;
    cycle(g);
    check("x0_we", 64'(rf_write_enable), 64'd0);
    check("x0_grant", 64'(grant_id), 64'd1);
    // Pointer now at 2: with everyone valid, source 2 wins.
    req_valid = '1;
    cycle(g);
    check("x0_ptr_next", 64'(grant_id), 64'd2);
    check("rf_x0", 64'(rf_mem[0]), 64'd0);

    // Scoreboard set by issue, cleared by the writeback.
    idle();
    issue_valid = 1'b1;
    issue_addr  = 5'd9;
    cycle(g);
    idle();
    query_addr_1 = 5'd9;
    req_valid    = 3'b100;
    src_addr[2]  = 5'd9;
    src_data[2]  = 32'h99;
    #2 check("sb_hazard_set", 64'(hazard_1), 64'd1);
    cycle(g);
    req_valid = '0;
    #2 check("sb_hazard_clr", 64'(hazard_1), 64'd0);
    cycle(g);

    // Same-cycle set and clear of x9: set wins; a second writeback clears.
    issue_valid = 1'b1;
    issue_addr  = 5'd9;
    cycle(g);
    req_valid   = 3'b100;
    src_data[2] = 32'h55;
    cycle(g);
    issue_valid = 1'b0;
    src_data[2] = 32'h66;
    #2 check("simul_set_wins", 64'(hazard_1), 64'd1);
    cycle(g);
    req_valid = '0;
    #2 check("simul_second_clr", 64'(hazard_1), 64'd0);
    cycle(g);

    // Reset right after an accepted transfer.
    issue_valid  = 1'b1;
    issue_addr   = 5'd3;
    query_addr_2 = 5'd3;
    cycle(g);
    issue_valid = 1'b0;
    req_valid   = 3'b001;
    src_addr[0] = 5'd10;
    src_data[0] = 32'h10;
    #2 check("mid_busy3", 64'(hazard_2), 64'd1);
    cycle(g);
    check("mid_we_before", 64'(rf_write_enable), 64'd1);
    reset     = 1'b1;
    req_valid = '0;
    cycle(g);
    check("mid_we_reset", 64'(rf_write_enable), 64'd0);
    check("mid_busy_reset", 64'(hazard_2), 64'd0);
    reset     = 1'b0;
    req_valid = '1;
    cycle(g);
    check("mid_ptr_reset", 64'(grant_id), 64'd0);
    last_g = g;

    // Randomized traffic. A source not granted keeps its request stable.
    for (int n = 0; n < 400; n++) begin
      reset = ($urandom_range(0, 63) == 0);
      for (int s = 0; s < NUM_REQ; s++) begin
        if (!req_valid[s] || s == last_g) begin
          req_valid[s] = 1'($urandom_range(0, 1));
          src_addr[s]  = 5'($urandom_range(0, 15));
          src_data[s]  = $urandom;
        end
      end
      issue_valid  = 1'($urandom_range(0, 1));
      issue_addr   = 5'($urandom_range(0, 15));
      query_addr_1 = 5'($urandom_range(0, 15));
      query_addr_2 = 5'($urandom_range(0, 15));
      cycle(g);
      last_g = g;
    end

    // Drain and compare the whole register file.
    reset = 1'b0;
    idle();
    cycle(g);
    cycle(g);
    for (int r = 0; r < 32; r++) check("rf_final", 64'(rf_mem[r]), 64'(m_regs[r]));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
